// File: rtl/tachyon_pkg.sv
// Shared definitions for the tachyon manifold stream generator and its consumer:
// ASCII codes, geometry helpers derived from the manifold width, and the
// generator FSM state encoding.
package tachyon_pkg;

  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_CARET = 8'h5E;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Centre column of a line of width w.
  function automatic int tm_center(input int w);
    return (w - 1) / 2;
  endfunction

  // Highest half-line index; the schematic has 2*max_y+1 lines.
  function automatic int tm_max_y(input int w);
    return (w - 1) / 2;
  endfunction

  // Number of splitter slots in the full pyramid (max_y*(max_y+1)/2).
  function automatic int tm_slots(input int w);
    return (w * w - 1) / 8;
  endfunction

  // Slot address width; never narrower than one bit.
  function automatic int tm_addr_w(input int w);
    return (tm_slots(w) > 1) ? $clog2(tm_slots(w)) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CHAR = 2'd1,
    ST_LF   = 2'd2,
    ST_DONE = 2'd3
  } tm_state_t;

endpackage

// File: rtl/splitter_mask_regs.sv
// SLOTS x 1 splitter population register file. One synchronous write port,
// one combinational read port. Resets to all ones (full pyramid); writes to
// addresses at or beyond SLOTS fall through every slot compare and are lost.
module splitter_mask_regs #(
  parameter int SLOTS = 6,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);

  logic [SLOTS-1:0] mask_q;

  // Write the addressed slot; reset restores the full pyramid.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '1;
    end else if (wr_en) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (wr_addr == AW'(i)) mask_q[i] <= wr_data;
      end
    end
  end

  // Combinational read of the slot selected by the running slot counter.
  always_comb begin
    rd_data = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (rd_addr == AW'(i)) rd_data = mask_q[i];
    end
  end

endmodule

// File: rtl/tachyon_manifold_stream_gen.sv
// Tachyon manifold schematic generator: emits one character per cycle of a
// pyramid manifold, line by line with LF terminators, splitter population
// taken from a writable mask.
//
// Stream handshake: a beat is transferred in every cycle where beam_in_valid
// is high. The consumer applies back-pressure with hold, which acts as an
// inverted ready sampled in the same cycle: while hold is high beam_in_valid
// is forced low, nothing advances, and the identical beat is offered again in
// the first cycle with hold low. hold has no effect outside CHAR/LF.
module tachyon_manifold_stream_gen
  import tachyon_pkg::*;
#(
  parameter int TACHYON_MANIFOLD_WIDTH = 7,
  localparam int AW = tm_addr_w(TACHYON_MANIFOLD_WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            hold,
  input  logic            mask_wr_en,
  input  logic [AW-1:0]   mask_wr_addr,
  input  logic            mask_wr_data,
  output logic            beam_empty,
  output logic            beam_enter,
  output logic            beam_splitter,
  output logic            beam_line_feed,
  output logic            beam_in_valid,
  output logic [7:0]      char_data,
  output logic            busy,
  output logic            done,
  output tm_state_t       debug_state
);

  localparam int W     = TACHYON_MANIFOLD_WIDTH;
  localparam int C     = tm_center(W);
  localparam int MAX_Y = tm_max_y(W);
  localparam int SLOTS = tm_slots(W);
  localparam int XW    = $clog2(W);

  localparam logic [XW-1:0] X_LAST     = XW'(W - 1);
  localparam logic [XW-1:0] X_CENTER   = XW'(C);
  localparam logic [XW-1:0] LINE_LAST  = XW'(2 * MAX_Y);
  localparam logic          CENTER_ODD = 1'(C % 2);

  tm_state_t     state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] line_q, line_d;
  logic [AW-1:0] slot_q, slot_d;

  logic [XW-1:0] k;
  logic [XW:0]   x_ext, span_lo, span_hi;
  logic          at_splitter;
  logic          mask_bit;
  logic          mask_we;
  logic          beat_live;

  // Mask writes only land while idle; anything during a run is dropped.
  assign mask_we = mask_wr_en && (state_q == ST_IDLE);

  splitter_mask_regs #(
    .SLOTS (SLOTS),
    .AW    (AW)
  ) u_mask (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mask_we),
    .wr_addr (mask_wr_addr),
    .wr_data (mask_wr_data),
    .rd_addr (slot_q),
    .rd_data (mask_bit)
  );

  // Splitter positions on line 2k run from C-(k-1) to C+(k-1) in steps of 2;
  // the step-of-2 test is a parity match between x and C+k-1.
  always_comb begin
    k           = line_q >> 1;
    x_ext       = {1'b0, x_q};
    span_lo     = (XW+1)'(C + 1) - {1'b0, k};
    span_hi     = (XW+1)'(C) + {1'b0, k} - (XW+1)'(1);
    at_splitter = (state_q == ST_CHAR) && !line_q[0] && (line_q != '0) &&
                  (x_ext >= span_lo) && (x_ext <= span_hi) &&
                  ((x_q[0] ^ line_q[1] ^ CENTER_ODD) == 1'b1);
  end

  // FSM and position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      line_q  <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      line_q  <= line_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state: walk x across a line, then LF, then the next line or DONE.
  // The slot counter steps at every splitter position, populated or not.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    line_d  = line_q;
    slot_d  = slot_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CHAR;
          x_d     = '0;
          line_d  = '0;
          slot_d  = '0;
        end
      end
      ST_CHAR: begin
        if (!hold) begin
          if (at_splitter) slot_d = slot_q + AW'(1);
          if (x_q == X_LAST) state_d = ST_LF;
          else               x_d     = x_q + XW'(1);
        end
      end
      ST_LF: begin
        if (!hold) begin
          if (line_q == LINE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CHAR;
            line_d  = line_q + XW'(1);
            x_d     = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat decode from the registered position; hold blanks the beat.
  always_comb begin
    beam_empty     = 1'b0;
    beam_enter     = 1'b0;
    beam_splitter  = 1'b0;
    beam_line_feed = 1'b0;
    char_data      = 8'h00;
    beat_live      = ((state_q == ST_CHAR) || (state_q == ST_LF)) && !hold;
    beam_in_valid  = beat_live;
    busy           = (state_q == ST_CHAR) || (state_q == ST_LF);
    done           = (state_q == ST_DONE);
    debug_state    = state_q;
    if (beat_live) begin
      if (state_q == ST_LF) begin
        beam_line_feed = 1'b1;
        char_data      = ASCII_LF;
      end else if ((line_q == '0) && (x_q == X_CENTER)) begin
        beam_enter = 1'b1;
        char_data  = ASCII_S;
      end else if (at_splitter && mask_bit) begin
        beam_splitter = 1'b1;
        char_data     = ASCII_CARET;
      end else begin
        beam_empty = 1'b1;
        char_data  = ASCII_DOT;
      end
    end
  end

  initial begin end

endmodule
